fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program counter / fetch unit driven by the control decoder's jump outputs. Holds PC and
//  presents it to the instruction ROM. Resolves conditional branches (absolute or PC-relative)
//  against ALU flags. Runs a Start/Done handshake with the testbench/host: load start
//  address, execute until the decoder flags Ack, then report Done plus an executed-instruction count.
// PARAMETERS
//  PC_W      10  width of program counter / ROM address
//  CNT_W     16  width of executed-instruction counter (saturating)
// PORTS
//  Clk             in   1      system clock, rising edge
//  Reset           in   1      asynchronous reset, active-low
//  Start           in   1      pulse: begin program at StartAddr (honoured in IDLE/DONE only)
//  StartAddr       in   PC_W   program entry address
//  Hold            in   1      freeze PC and counter this cycle (RUN only)
//  ConditionalJump in   1      decoder: current instruction is a branch
//  BranchAbsOrRel  in   1      decoder: 0 = absolute target, 1 = PC-relative
//  BranchConditions in  2      decoder: 00 always, 01 Zero=1, 10 Zero=0, 11 Neg=1
//  Ack             in   1      decoder: current instruction is the halt instruction
//  FlagZero        in   1      ALU zero flag (registered by CMP, valid this cycle)
//  FlagNeg         in   1      ALU negative flag (registered by CMP, valid this cycle)
//  TargetVal       in   8      register-file read data A: branch target/offset
//  ProgCtr         out  PC_W   instruction ROM address
//  Running         out  1      high in RUN
//  Done            out  1      high in DONE
//  InstrCount      out  CNT_W  instructions retired since last Start
// BEHAVIOUR
//  Reset (Reset=0, async): state IDLE, ProgCtr=0, Running=0, Done=0, InstrCount=0.
//  States: IDLE, RUN, DONE (registered). Outputs Running/Done decoded from state (no extra latency).
//  IDLE:  Start=1 -> ProgCtr<=StartAddr, InstrCount<=0, RUN. Otherwise hold.
//  RUN, per edge, priority Hold > Ack > branch > increment:
//   - Hold=1: no change to ProgCtr, InstrCount or state.
//   - Ack=1: ProgCtr held, InstrCount+1, -> DONE. Ack wins over ConditionalJump.
//   - taken branch: ConditionalJump=1 and condition true ->
//       Abs: ProgCtr <= {zeros, TargetVal} (zero-extended to PC_W).
//       Rel: ProgCtr <= ProgCtr + sign-extend(TargetVal) (range -128..+127).
//   - else ProgCtr <= ProgCtr + 1 (also for not-taken branch).
//   - InstrCount+1 on every non-Hold RUN edge.
//   - Start ignored in RUN.
//  DONE:  ProgCtr and InstrCount held, Done=1. Start=1 -> reload as from IDLE (Done low next cycle).
//  Arithmetic: ProgCtr wraps mod 2^PC_W on increment and on relative add (no fault).
//  InstrCount saturates at all-ones; never wraps.
//  Branch/flag inputs sampled only in RUN; ignored in IDLE/DONE.
//  Reset asserted mid-RUN: immediate return to reset values; in-flight branch discarded.
//  Latency: branch decision takes effect on the edge ending the branch instruction (0 bubbles).
// TESTING
//  1 Reset low mid-RUN at ProgCtr=0x05 -> ProgCtr=0, IDLE, Done=0 immediately, before next edge.
//  2 Start, StartAddr=0x010; 3 plain instrs then Ack -> ProgCtr 10,11,12,13 held; Done=1; InstrCount=4.
//  3 RUN at 0x020, Jump Rel, cond 01, FlagZero=1, TargetVal=0xFC -> ProgCtr=0x01C; FlagZero=0 -> 0x021.
//  4 RUN at 0x020, Jump Abs, cond 00, TargetVal=0x80 -> ProgCtr=0x080; cond 11 with FlagNeg=0 -> 0x021.
//  5 ProgCtr=0x3FF increment -> 0x000; ProgCtr=0x002 Rel TargetVal=0x80 -> 0x382 (wrap).
//  6 Hold=1 for 3 cycles with Ack=1 -> no change; Hold drops -> DONE; Start in DONE -> RUN, count=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Program counter / fetch unit. Holds the PC that addresses the instruction
//   ROM and advances it every executed instruction. It resolves conditional
//   branches (absolute or PC-relative) against the ALU flags. It also runs a
//   Start/Done handshake with the host: load an entry address, execute until
//   the decoder flags the halt instruction, then report Done together with
//   the number of instructions retired.
//
// Ports
//   Clk              in   system clock, rising edge
//   Reset            in   asynchronous reset, active-low
//   Start            in   begin program at StartAddr (IDLE/DONE only)
//   StartAddr        in   program entry address [PC_W]
//   Hold             in   freeze PC and counter this cycle (RUN only)
//   ConditionalJump  in   current instruction is a branch
//   BranchAbsOrRel   in   0 = absolute target, 1 = PC-relative
//   BranchConditions in   00 always, 01 Zero=1, 10 Zero=0, 11 Neg=1
//   Ack              in   current instruction is the halt instruction
//   FlagZero         in   ALU zero flag
//   FlagNeg          in   ALU negative flag
//   TargetVal        in   branch target (absolute) or signed offset [8]
//   ProgCtr          out  instruction ROM address [PC_W]
//   Running          out  high while executing
//   Done             out  high after the halt instruction retired
//   InstrCount       out  instructions retired since last Start [CNT_W]
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Hold,
  input  logic             ConditionalJump,
  input  logic             BranchAbsOrRel,
  input  logic [1:0]       BranchConditions,
  input  logic             Ack,
  input  logic             FlagZero,
  input  logic             FlagNeg,
  input  logic [7:0]       TargetVal,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             condTrue;
  logic [PC_W-1:0]  absTarget;
  logic [PC_W-1:0]  relTarget;
  logic [CNT_W-1:0] cntInc;

  // Branch condition evaluation from the decoder's condition code.
  always_comb begin
    condTrue = 1'b0;
    case (BranchConditions)
      2'b00:   condTrue = 1'b1;
      2'b01:   condTrue = FlagZero;
      2'b10:   condTrue = ~FlagZero;
      default: condTrue = FlagNeg;
    endcase
  end

  // Absolute targets are zero-extended; relative offsets are sign-extended
  // so the add wraps naturally modulo 2^PC_W.
  assign absTarget = {{(PC_W-8){1'b0}}, TargetVal};
  assign relTarget = pc_q + {{(PC_W-8){TargetVal[7]}}, TargetVal};

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  assign cntInc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic. In RUN the priority is Hold > Ack > branch > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!Hold) begin
          cnt_d = cntInc;
          if (Ack) begin
            state_d = DONE;
          end else if (ConditionalJump && condTrue) begin
            pc_d = BranchAbsOrRel ? relTarget : absTarget;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        // IDLE and DONE both wait for Start and ignore all decoder inputs.
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ProgCtr    = pc_q;
  assign InstrCount = cnt_q;
  assign Running    = (state_q == RUN);
  assign Done       = (state_q == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. A behavioural model tracks the PC,
//   retired count and mode using plain integer arithmetic and is compared
//   against the DUT on every falling clock edge. Literal checks after key
//   steps pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             Hold;
  logic             ConditionalJump;
  logic             BranchAbsOrRel;
  logic [1:0]       BranchConditions;
  logic             Ack;
  logic             FlagZero;
  logic             FlagNeg;
  logic [7:0]       TargetVal;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] InstrCount;

  int vecCount = 0;
  int errCount = 0;

  fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Start            (Start),
    .StartAddr        (StartAddr),
    .Hold             (Hold),
    .ConditionalJump  (ConditionalJump),
    .BranchAbsOrRel   (BranchAbsOrRel),
    .BranchConditions (BranchConditions),
    .Ack              (Ack),
    .FlagZero         (FlagZero),
    .FlagNeg          (FlagNeg),
    .TargetVal        (TargetVal),
    .ProgCtr          (ProgCtr),
    .Running          (Running),
    .Done             (Done),
    .InstrCount       (InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: mode 0 = idle, 1 = executing, 2 = finished.
  int mPc   = 0;
  int mCnt  = 0;
  int mMode = 0;

  // Model update: applies the instruction-level rules to the inputs present
  // at each rising edge, or returns to power-on values when reset drops.
  always @(posedge Clk or negedge Reset) begin
    int  off;
    bit  take;
    if (!Reset) begin
      mPc   = 0;
      mCnt  = 0;
      mMode = 0;
    end else if (mMode == 1) begin
      if (!Hold) begin
        if (mCnt < 65535) mCnt = mCnt + 1;
        if (Ack) begin
          mMode = 2;
        end else begin
          case (BranchConditions)
            2'b00:   take = 1'b1;
            2'b01:   take = FlagZero;
            2'b10:   take = !FlagZero;
            default: take = FlagNeg;
          endcase
          if (ConditionalJump && take) begin
            if (BranchAbsOrRel) begin
              off = (TargetVal >= 128) ? int'(TargetVal) - 256 : int'(TargetVal);
              mPc = (mPc + off + 1024) % 1024;
            end else begin
              mPc = int'(TargetVal);
            end
          end else begin
            mPc = (mPc + 1) % 1024;
          end
        end
      end
    end else if (Start) begin
      mPc   = int'(StartAddr);
      mCnt  = 0;
      mMode = 1;
    end
  end

  // Single comparison point used by both the per-cycle compare and the
  // hand-computed literal checks.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare of the DUT against the model, away from the rising edge.
  always @(negedge Clk) begin
    checkOutput("model ProgCtr",    int'(ProgCtr),    mPc);
    checkOutput("model InstrCount", int'(InstrCount), mCnt);
    checkOutput("model Running",    int'(Running),    int'(mMode == 1));
    checkOutput("model Done",       int'(Done),       int'(mMode == 2));
  end

  // Drive one cycle of inputs shortly after the falling edge, then return
  // just after the following rising edge so the result can be inspected.
  task automatic applyStimulus(input bit st, input int addr, input bit hold,
                               input bit cj, input bit rel, input int cond,
                               input bit ack, input bit z, input bit n, input int tv);
    @(negedge Clk);
    #1;
    Start            = st;
    StartAddr        = PC_W'(addr);
    Hold             = hold;
    ConditionalJump  = cj;
    BranchAbsOrRel   = rel;
    BranchConditions = 2'(cond);
    Ack              = ack;
    FlagZero         = z;
    FlagNeg          = n;
    TargetVal        = 8'(tv);
    @(posedge Clk);
    #1;
  endtask

  task automatic plain();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic halt();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic startAt(input int addr);
    applyStimulus(1, addr, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkState(input string tag, input int pc, input int cnt,
                            input bit run, input bit dn);
    checkOutput({tag, " ProgCtr"},    int'(ProgCtr),    pc);
    checkOutput({tag, " InstrCount"}, int'(InstrCount), cnt);
    checkOutput({tag, " Running"},    int'(Running),    int'(run));
    checkOutput({tag, " Done"},       int'(Done),       int'(dn));
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    StartAddr = '0;
    Hold = 1'b0;
    ConditionalJump = 1'b0;
    BranchAbsOrRel = 1'b0;
    BranchConditions = 2'b00;
    Ack = 1'b0;
    FlagZero = 1'b0;
    FlagNeg = 1'b0;
    TargetVal = 8'h00;

    #12;
    checkState("reset", 0, 0, 0, 0);
    @(negedge Clk);
    #1 Reset = 1'b1;

    // Reset asserted mid-execution clears everything before the next edge.
    startAt(10'h003);
    plain();
    plain();
    checkState("pre-reset", 10'h005, 2, 1, 0);
    #1 Reset = 1'b0;
    #1;
    checkState("async reset", 0, 0, 0, 0);
    @(negedge Clk);
    #1 Reset = 1'b1;

    // Straight-line program ending in the halt instruction.
    startAt(10'h010);
    checkState("start 010", 10'h010, 0, 1, 0);
    plain();
    plain();
    plain();
    checkState("seq 013", 10'h013, 3, 1, 0);
    halt();
    checkState("halt", 10'h013, 4, 0, 1);
    // Decoder inputs are ignored while finished.
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h99);
    checkState("done ignores jump", 10'h013, 4, 0, 1);

    // Relative branch on Zero=1, taken then not taken.
    startAt(10'h020);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 1, 0, 8'hFC);
    checkOutput("rel zero taken", int'(ProgCtr), 10'h01C);
    halt();
    startAt(10'h020);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, 0, 8'hFC);
    checkOutput("rel zero not taken", int'(ProgCtr), 10'h021);
    halt();

    // Absolute branches: unconditional, Neg clear, then Neg set / Zero clear.
    startAt(10'h020);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h80);
    checkOutput("abs always", int'(ProgCtr), 10'h080);
    halt();
    startAt(10'h020);
    applyStimulus(0, 0, 0, 1, 0, 3, 0, 0, 0, 8'h80);
    checkOutput("abs neg clear", int'(ProgCtr), 10'h021);
    applyStimulus(0, 0, 0, 1, 1, 3, 0, 0, 1, 8'h05);
    checkOutput("rel neg set", int'(ProgCtr), 10'h026);
    applyStimulus(0, 0, 0, 1, 0, 2, 0, 0, 0, 8'h33);
    checkOutput("abs zero clear", int'(ProgCtr), 10'h033);
    // Ack wins over a simultaneous taken branch.
    applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h77);
    checkState("ack over jump", 10'h033, 4, 0, 1);

    // Wraparound on increment and on a negative relative offset.
    startAt(10'h3FF);
    plain();
    checkOutput("inc wrap", int'(ProgCtr), 10'h000);
    halt();
    startAt(10'h002);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h80);
    checkOutput("rel wrap", int'(ProgCtr), 10'h382);
    halt();

    // Hold overrides Ack; release completes; Start in DONE reloads.
    startAt(10'h040);
    plain();
    repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    checkState("hold", 10'h041, 1, 1, 0);
    halt();
    checkState("hold released", 10'h041, 2, 0, 1);
    startAt(10'h050);
    checkState("restart", 10'h050, 0, 1, 0);
    // Start is ignored while running.
    applyStimulus(1, 10'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    checkState("start in run", 10'h051, 1, 1, 0);

    repeat (2) @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
